// File: rtl/maj_chk_pkg.sv
// Shared types, segment codes and the golden majority function for the sweep checker.
package maj_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_F     = 8'h8E;

  // Golden result: more than half of the n_in low bits are set.
  function automatic logic majority(input logic [7:0] code, input int unsigned n_in);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n_in)) ones += 32'(code[i]);
    end
    return ones > (n_in / 2);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low 7-segment pattern {dp,g..a}; dp is always off.
module hex7seg (
  input  logic [3:0] value,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    case (value)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/majority_sweep_checker.sv
// Exhaustive sweep checker for the majority datapath: drives every code, samples, counts mismatches.
// Build option MAJ_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | current code on dut_in, settle timer loaded
// SETTLE | timer counting down while the DUT settles
// SAMPLE | compare dut_out against golden, advance or finish
// DONE   | results held, waiting for start
module majority_sweep_checker
  import maj_chk_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic [7:0]      hex0,
  output logic [7:0]      hex1
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N_IN-1:0] CODE_MAX = '1;
  localparam logic [N_IN:0]   ERR_MAX  = '1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N_IN-1:0] dut_in_nxt, first_fail_nxt;
  logic [N_IN:0]   err_nxt;
  logic            busy_nxt, done_nxt, pass_nxt;
  logic            expected, mismatch, finish;
  logic [7:0]      ff_ext, seg0;

  assign expected = majority(8'(dut_in), N_IN);
  assign mismatch = (dut_out != expected);
  assign ff_ext   = 8'(first_fail);

  hex7seg u_hex0 (
    .value (ff_ext[3:0]),
    .seg   (seg0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      hex0       <= SEG_BLANK;
      hex1       <= SEG_BLANK;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dut_in     <= dut_in_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      first_fail <= first_fail_nxt;
      // Display follows the registered flags, so it lags done by one cycle.
      hex0       <= done ? seg0 : SEG_BLANK;
      hex1       <= done ? (pass ? SEG_P : SEG_F) : SEG_BLANK;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    dut_in_nxt     = dut_in;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_nxt        = err_count;
    first_fail_nxt = first_fail;
    finish         = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = DRIVE;
          dut_in_nxt     = '0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          err_nxt        = '0;
          first_fail_nxt = '0;
        end
      end
      DRIVE: begin
        cnt_nxt   = CW'(SETTLE_CYC - 1);
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = SAMPLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_nxt = err_count + 1'b1;
          // err_count is still zero only before the first mismatch of this sweep
          if (err_count == '0) first_fail_nxt = dut_in;
        end
`ifdef MAJ_CHK_STOP_ON_FAIL_EN
        finish = mismatch || (dut_in == CODE_MAX);
`else
        finish = (dut_in == CODE_MAX);
`endif
        if (finish) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
        end else begin
          dut_in_nxt = dut_in + 1'b1;
          state_nxt  = DRIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
